shift_rows_pipe: RTL and testbench
==================================

// Module: shift_rows_pipe
// PURPOSE
//  Parametrised, pipelined Rijndael ShiftRows / InvShiftRows unit with valid/ready flow control.
//  Supports block widths Nb = 4/6/8 columns (128/192/256-bit state).
//  Direction is selected per transaction.
//  Sits between SubBytes/InvSubBytes and MixColumns in the round datapath.
//  Replaces the fixed 128-bit combinational inverse-only shifter.
// PARAMETERS
//  NB      4  state columns; legal 4, 6, 8; any other value is an elaboration error
//  STAGES  1  pipeline register stages; legal 1..3; latency = STAGES cycles
//  W       32*NB  state width (derived, not overridable)
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  clear      in   1  synchronous flush; drops all in-flight data
//  in_valid   in   1  input data valid
//  in_ready   out  1  unit can accept input this cycle
//  in_inv     in   1  0 = forward ShiftRows, 1 = InvShiftRows
//  in_data    in   W  input state
//  out_valid  out  1  output data valid
//  out_ready  in   1  downstream accepts output
//  out_data   out  W  shifted state
//  busy       out  1  any stage holds valid data
// BEHAVIOUR
//  State layout: column c = data[W-1-32c -: 32], c = 0..NB-1.
//   Row r byte of a column = bits [31-8r -: 8]; column 0 at the MSBs.
//  Row shift amounts s(r), r = 0..3:
//   NB = 4 or 6: 0, 1, 2, 3
//   NB = 8:      0, 1, 3, 4
//  Forward: out[r][c] = in[r][(c + s(r)) mod NB]   (rotate row left)
//  Inverse: out[r][c] = in[r][(c - s(r)) mod NB]   (rotate row right)
//   The mod wrap must be correct for NB = 6 (non-power-of-two).
//  Permutation is applied combinationally on in_data and captured into stage 0.
//   in_inv is sampled with the same handshake as the data.
//  Stage i: data register d[i] (W bits) plus valid flag v[i].
//   stage_ready[i] = !v[i] | stage_ready[i+1]
//   stage_ready[STAGES] = out_ready
//  in_ready = stage_ready[0]; accept on in_valid & in_ready.
//  Stage i loads from stage i-1 (stage 0 loads from the permuted input) when stage_ready[i].
//   When loading, v[i] takes the upstream valid.
//  Full throughput: one state per cycle when out_ready is held high.
//   Bubbles collapse when out_ready is low.
//  out_valid = v[STAGES-1]; out_data = d[STAGES-1].
//   out_data must stay stable while out_valid & !out_ready.
//  Latency: a state accepted in cycle t appears on out_valid in cycle t+STAGES,
//   provided no back-pressure occurs.
//  busy = OR of all v[i].
//  Reset (rst_n low, asynchronous): all v[i] = 0 and all d[i] = 0.
//   Outputs: out_valid = 0, out_data = 0, busy = 0.
//   in_ready = 1 once rst_n is released.
//  Reset mid-stream discards data immediately; no partial output.
//  clear: on a clk edge with clear = 1, all v[i] = 0 and the input handshake is ignored.
//   d[i] keep their values; in_ready = 0 while clear = 1.
//  Input and output handshakes in the same cycle with all stages full:
//   the pipeline shifts and accepts the new input; no loss, no duplication.
//  There are no other state bits; the datapath is permutation only (no arithmetic).
// TESTING
//  T1 NB=4, fwd, in=000102030405060708090a0b0c0d0e0f
//     -> out=00050a0f04090e03080d02070c01060b after STAGES cycles
//  T2 NB=4, inv, in=000102030405060708090a0b0c0d0e0f
//     -> out=000d0a0704010e0b0805020f0c090603
//  T3 NB=6 and NB=8: random states; check fwd->inv round trip = identity.
//     Check NB=8 row 3 rotated by 4 columns; check 1000 vectors against a reference model.
//  T4 STAGES=3: stream 16 states with random out_ready stalls
//     -> order preserved, no drop or duplicate, out_data stable while stalled.
//  T5 Alternate in_inv every cycle at full rate -> each output matches its own mode.
//  T6 Assert rst_n low mid-stream -> out_valid=0 and busy=0 immediately.
//     Assert clear with 3 in flight -> next out_valid only for data accepted after clear.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for Nb = 4/6/8 columns.
// Each stage passes data forward with valid/ready handshakes, and bubbles in the pipeline collapse.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    localparam int W     = 32 * NB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..3");
    end

    logic [W-1:0]      perm;
    logic [W-1:0]      d    [STAGES];
    logic [W-1:0]      up_d [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] stage_ready;

    // Pure byte wiring: source columns are resolved at elaboration, so NB = 6 wraps correctly.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SH      = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int FWD_SRC = (c + SH) % NB;
            localparam int INV_SRC = (c + NB - SH) % NB;
            assign perm[W-1-32*c-8*r -: 8] = in_inv ? in_data[W-1-32*INV_SRC-8*r -: 8]
                                                    : in_data[W-1-32*FWD_SRC-8*r -: 8];
        end
    end

    // A stage can advance when any stage from it to the output has a hole, or the sink takes data.
    for (genvar i = 0; i < STAGES; i++) begin : g_ready
        assign stage_ready[i] = out_ready | ~(&v[STAGES-1:i]);
    end

    assign up_v[0] = in_valid;
    assign up_d[0] = perm;
    for (genvar i = 1; i < STAGES; i++) begin : g_link
        assign up_v[i] = v[i-1];
        assign up_d[i] = d[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
        end else if (clear) begin
            v <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (stage_ready[i]) begin
                    v[i] <= up_v[i];
                    d[i] <= up_d[i];
                end
            end
        end
    end

    assign in_ready  = stage_ready[0] & ~clear;
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];
    assign busy      = |v;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench: NB=4/STAGES=3, NB=6/STAGES=2 and NB=8/STAGES=1 instances share one stimulus
// stream, and each instance is scored against a row-rotation model of the state matrix.
module tb_shift_rows_pipe;

    logic         clk = 0;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         in_inv;
    logic         out_ready;
    logic [255:0] stim;

    logic         ir4, ov4, busy4;
    logic [127:0] od4;
    logic         ir6, ov6, busy6;
    logic [191:0] od6;
    logic         ir8, ov8, busy8;
    logic [255:0] od8;

    int checks = 0;
    int errors = 0;

    logic [255:0] expq [3][$];
    bit           stall_prev [3];
    logic [255:0] held_data  [3];

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .STAGES(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir4),
        .in_inv(in_inv), .in_data(stim[127:0]), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .busy(busy4));

    shift_rows_pipe #(.NB(6), .STAGES(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir6),
        .in_inv(in_inv), .in_data(stim[191:0]), .out_valid(ov6), .out_ready(out_ready),
        .out_data(od6), .busy(busy6));

    shift_rows_pipe #(.NB(8), .STAGES(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir8),
        .in_inv(in_inv), .in_data(stim), .out_valid(ov8), .out_ready(out_ready),
        .out_data(od8), .busy(busy8));

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Treat the state as a 4 x nb byte matrix and rotate each row by its shift amount.
    function automatic logic [255:0] refShift(input logic [255:0] x, input int nb, input bit inv);
        int           shtab [4];
        logic [7:0]   m [4][8];
        logic [255:0] res;
        int           top, src;
        if (nb == 8) shtab = '{0, 1, 3, 4};
        else         shtab = '{0, 1, 2, 3};
        top = 32 * nb - 1;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = x[top-32*c-8*r -: 8];
        res = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - shtab[r] + nb) % nb : (c + shtab[r]) % nb;
                res[top-32*c-8*r -: 8] = m[r][src];
            end
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] x;
        for (int k = 0; k < 8; k++) x[32*k +: 32] = $urandom;
        return x;
    endfunction

    task automatic monitorDut(input int id, input int nb, input logic in_rdy, input logic o_vld,
                              input logic [255:0] o_dat);
        logic [255:0] x;
        if (stall_prev[id]) begin
            checkOutput($sformatf("nb%0d_stall_valid", nb), {255'b0, o_vld}, 256'd1);
            checkOutput($sformatf("nb%0d_stall_data", nb), o_dat, held_data[id]);
        end
        if (in_valid && in_rdy) begin
            x = stim;
            for (int b = 32 * nb; b < 256; b++) x[b] = 1'b0;
            expq[id].push_back(refShift(x, nb, in_inv));
        end
        if (o_vld && out_ready) begin
            if (expq[id].size() == 0)
                checkOutput($sformatf("nb%0d_unexpected_out", nb), 256'd1, 256'd0);
            else
                checkOutput($sformatf("nb%0d_out", nb), o_dat, expq[id].pop_front());
        end
        stall_prev[id] = o_vld && !out_ready;
        held_data[id]  = o_dat;
        if (clear) begin
            expq[id].delete();
            stall_prev[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int id = 0; id < 3; id++) begin
                expq[id].delete();
                stall_prev[id] = 0;
            end
        end else begin
            monitorDut(0, 4, ir4, ov4, {128'b0, od4});
            monitorDut(1, 6, ir6, ov6, {64'b0, od6});
            monitorDut(2, 8, ir8, ov8, od8);
        end
    end

    task automatic applyStimulus(input logic [255:0] data, input bit inv);
        bit ok = 0;
        @(posedge clk); #1;
        stim = data; in_inv = inv; in_valid = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ir4 && ir6 && ir8) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) checkOutput("accept_timeout", 256'd0, 256'd1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic waitOut(input int nb, output logic [255:0] dat, output int n);
        logic vld;
        dat = '0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            vld = (nb == 4) ? ov4 : (nb == 6) ? ov6 : ov8;
            if (vld) begin
                dat = (nb == 4) ? {128'b0, od4} : (nb == 6) ? {64'b0, od6} : od8;
                return;
            end
        end
        checkOutput($sformatf("nb%0d_out_timeout", nb), 256'd0, 256'd1);
    endtask

    task automatic drainAndCheck(input string tag);
        in_valid = 0; out_ready = 1;
        repeat (8) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++)
            checkOutput($sformatf("%s_left_%0d", tag, id), expq[id].size(), 256'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] x, y, z;
        int n;

        rst_n = 0; clear = 0; in_valid = 0; in_inv = 0; out_ready = 1; stim = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {ov8, ov6, ov4}, 256'd0);
        checkOutput("reset_busy", {busy8, busy6, busy4}, 256'd0);
        checkOutput("reset_out_data4", od4, 256'd0);
        checkOutput("reset_out_data8", od8, 256'd0);
        rst_n = 1;
        #1;
        checkOutput("reset_in_ready", {ir8, ir6, ir4}, 256'd7);

        // Known-answer vectors, including three-cycle latency on the NB=4 instance
        applyStimulus(256'h000102030405060708090a0b0c0d0e0f, 0);
        waitOut(4, y, n);
        checkOutput("t1_latency", n, 256'd3);
        checkOutput("t1_data", y, 256'h00050a0f04090e03080d02070c01060b);
        applyStimulus(256'h000102030405060708090a0b0c0d0e0f, 1);
        waitOut(4, y, n);
        checkOutput("t2_data", y, 256'h000d0a0704010e0b0805020f0c090603);
        drainAndCheck("kat");

        // Round trip through the hardware: forward then inverse must restore the input
        for (int t = 0; t < 4; t++) begin
            x = rand256();
            applyStimulus(x, 0);
            waitOut(8, y, n);
            for (int c = 0; c < 8; c++)
                checkOutput("nb8_row3_rot4", y[255-32*c-24 -: 8], x[255-32*((c+4)%8)-24 -: 8]);
            applyStimulus(y, 1);
            waitOut(8, z, n);
            checkOutput("nb8_roundtrip", z, x);
            x = rand256();
            applyStimulus(x, 0);
            waitOut(6, y, n);
            applyStimulus(y, 1);
            waitOut(6, z, n);
            checkOutput("nb6_roundtrip", z, {64'b0, x[191:0]});
            drainAndCheck("rt");
        end

        // Full rate with the direction flipping every cycle
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            in_valid = 1; in_inv = k[0]; stim = rand256();
        end
        drainAndCheck("alt");

        // Random valid, back-pressure and direction
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_inv    = $urandom_range(0, 1);
            stim      = rand256();
        end
        drainAndCheck("rand");

        // Flush three in-flight states, then only post-clear data may emerge
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1; in_inv = $urandom_range(0, 1); stim = rand256();
        end
        @(posedge clk); #1;
        in_valid = 0;
        checkOutput("pre_clear_full", {busy4, ov4, ir4}, 256'd6);
        clear = 1;
        #1;
        checkOutput("clear_in_ready", {ir8, ir6, ir4}, 256'd0);
        @(posedge clk); #1;
        clear = 0;
        checkOutput("clear_busy", {busy8, busy6, busy4}, 256'd0);
        checkOutput("clear_out_valid", {ov8, ov6, ov4}, 256'd0);
        out_ready = 1;
        applyStimulus(rand256(), 0);
        waitOut(4, y, n);
        checkOutput("post_clear_latency", n, 256'd3);
        drainAndCheck("clear");

        // Asynchronous reset while a state is in flight
        applyStimulus(rand256(), 1);
        checkOutput("pre_reset_busy4", busy4, 256'd1);
        rst_n = 0;
        #1;
        checkOutput("reset_mid_out_valid", {ov8, ov6, ov4}, 256'd0);
        checkOutput("reset_mid_busy", {busy8, busy6, busy4}, 256'd0);
        checkOutput("reset_mid_data4", od4, 256'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        checkOutput("reset_release_ready", {ir8, ir6, ir4}, 256'd7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("post_reset_no_out", {ov8, ov6, ov4}, 256'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
